// File: rtl/mac16_dsp.sv
// mac16_dsp: 16x16 (or dual 8x8) multiply-add/accumulate slice with optional operand registers
// and a registered 32-bit result. Define MAC16_OVF_DETECT_EN to build the signed-overflow flag.
`timescale 1ns/1ps
module mac16_dsp #(
  parameter bit A_SIGNED = 1'b1,
  parameter bit B_SIGNED = 1'b1,
  parameter bit A_REG    = 1'b1,
  parameter bit B_REG    = 1'b1,
  parameter bit C_REG    = 1'b1,
  parameter bit D_REG    = 1'b0,
  parameter bit MODE_8X8 = 1'b0,
  parameter bit ACCUM    = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic        ahold,
  input  logic        bhold,
  input  logic        chold,
  input  logic        dhold,
  input  logic        addsub,
  input  logic        oload,
  input  logic        ohold,
  output logic [31:0] o,
  output logic        co,
  output logic        ovf
);

  // Add or subtract with carry out; subtraction is x + ~y + 1, so the carry is "no borrow".
  function automatic logic [32:0] addsub32(input logic [31:0] x, input logic [31:0] y,
                                           input logic sub);
    logic [31:0] ye;
    ye = sub ? ~y : y;
    return {1'b0, x} + {1'b0, ye} + {32'b0, sub};
  endfunction

  function automatic logic [16:0] addsub16(input logic [15:0] x, input logic [15:0] y,
                                           input logic sub);
    logic [15:0] ye;
    ye = sub ? ~y : y;
    return {1'b0, x} + {1'b0, ye} + {16'b0, sub};
  endfunction

  // ---- stage p0: optional operand registers ----
  logic [15:0] a_p0_q, a_p0_d;
  logic [15:0] b_p0_q, b_p0_d;
  logic [15:0] c_p0_q, c_p0_d;
  logic [15:0] d_p0_q, d_p0_d;

  always_comb begin
    a_p0_d = a_p0_q;
    b_p0_d = b_p0_q;
    c_p0_d = c_p0_q;
    d_p0_d = d_p0_q;
    if (ce) begin
      if (!ahold) a_p0_d = a;
      if (!bhold) b_p0_d = b;
      if (!chold) c_p0_d = c;
      if (!dhold) d_p0_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_p0_q <= '0;
      b_p0_q <= '0;
      c_p0_q <= '0;
      d_p0_q <= '0;
    end else begin
      a_p0_q <= a_p0_d;
      b_p0_q <= b_p0_d;
      c_p0_q <= c_p0_d;
      d_p0_q <= d_p0_d;
    end
  end

  logic [15:0] a_s, b_s, c_s, d_s;

  always_comb begin
    a_s = A_REG ? a_p0_q : a;
    b_s = B_REG ? b_p0_q : b;
    c_s = C_REG ? c_p0_q : c;
    d_s = D_REG ? d_p0_q : d;
  end

  // ---- multiplier: one 16x16 product or two independent 8x8 lane products ----
  logic signed [31:0] a_w, b_w, p16_w;
  logic signed [15:0] ah_w, bh_w, al_w, bl_w, ph_w, pl_w;
  logic        [31:0] p_w;

  always_comb begin
    a_w   = A_SIGNED ? $signed({{16{a_s[15]}}, a_s}) : $signed({16'b0, a_s});
    b_w   = B_SIGNED ? $signed({{16{b_s[15]}}, b_s}) : $signed({16'b0, b_s});
    p16_w = a_w * b_w;
    ah_w  = A_SIGNED ? $signed({{8{a_s[15]}}, a_s[15:8]}) : $signed({8'b0, a_s[15:8]});
    bh_w  = B_SIGNED ? $signed({{8{b_s[15]}}, b_s[15:8]}) : $signed({8'b0, b_s[15:8]});
    al_w  = A_SIGNED ? $signed({{8{a_s[7]}}, a_s[7:0]}) : $signed({8'b0, a_s[7:0]});
    bl_w  = B_SIGNED ? $signed({{8{b_s[7]}}, b_s[7:0]}) : $signed({8'b0, b_s[7:0]});
    ph_w  = ah_w * bh_w;
    pl_w  = al_w * bl_w;
    p_w   = MODE_8X8 ? {ph_w, pl_w} : p16_w;
  end

  // ---- adder: full 32-bit path and split lanes; the lo lane carry is simply dropped ----
  logic [31:0] x32_w, y32_w;
  logic [32:0] s32_w;
  logic [15:0] xh_w, yh_w, xl_w, yl_w, sl_w;
  logic [16:0] sh_w;
  logic [31:0] res_w;
  logic        cout_w;

  always_comb begin
    x32_w  = ACCUM ? o : p_w;
    y32_w  = ACCUM ? p_w : {{16{c_s[15]}}, c_s};
    s32_w  = addsub32(x32_w, y32_w, addsub);
    xh_w   = ACCUM ? o[31:16] : p_w[31:16];
    yh_w   = ACCUM ? p_w[31:16] : c_s;
    xl_w   = ACCUM ? o[15:0] : p_w[15:0];
    yl_w   = ACCUM ? p_w[15:0] : d_s;
    sh_w   = addsub16(xh_w, yh_w, addsub);
    sl_w   = xl_w + (addsub ? ~yl_w : yl_w) + {15'b0, addsub};
    res_w  = MODE_8X8 ? {sh_w[15:0], sl_w} : s32_w[31:0];
    cout_w = MODE_8X8 ? sh_w[16] : s32_w[32];
  end

  // ---- stage p1: output register (oload > ohold > compute) ----
  logic [31:0] o_p1_q, o_p1_d;
  logic        co_p1_q, co_p1_d;

  always_comb begin
    o_p1_d  = o_p1_q;
    co_p1_d = co_p1_q;
    if (ce) begin
      if (oload) begin
        o_p1_d  = {c, d};
        co_p1_d = 1'b0;
      end else if (!ohold) begin
        o_p1_d  = res_w;
        co_p1_d = cout_w;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_p1_q  <= '0;
      co_p1_q <= 1'b0;
    end else begin
      o_p1_q  <= o_p1_d;
      co_p1_q <= co_p1_d;
    end
  end

  assign o  = o_p1_q;
  assign co = co_p1_q;

`ifdef MAC16_OVF_DETECT_EN
  // Overflow: effective operands share a sign but the result sign differs.
  function automatic logic ovf_bit(input logic xs, input logic ys, input logic rs,
                                   input logic sub);
    logic ye;
    ye = ys ^ sub;
    return (xs == ye) && (rs != xs);
  endfunction

  logic ovf_p1_q, ovf_p1_d, ovf_w;

  always_comb begin
    ovf_w = MODE_8X8 ? ovf_bit(xh_w[15], yh_w[15], sh_w[15], addsub)
                     : ovf_bit(x32_w[31], y32_w[31], s32_w[31], addsub);
    ovf_p1_d = ovf_p1_q;
    if (ce) begin
      if (oload) ovf_p1_d = 1'b0;
      else if (!ohold) ovf_p1_d = ovf_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_p1_q <= 1'b0;
    else        ovf_p1_q <= ovf_p1_d;
  end

  assign ovf = ovf_p1_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mac16_dsp.sv
// Bench for mac16_dsp: table vectors, hand sequences and random stimulus against
// an arithmetic reference model, over five parameter variants sharing one input bus.
`timescale 1ns/1ps
module tb_mac16_dsp;
  localparam int NI = 5;
`ifdef MAC16_OVF_DETECT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct {
    bit a_signed, b_signed, a_reg, b_reg, c_reg, d_reg, mode8, accum;
  } cfg_t;
  typedef struct {
    logic [15:0] ar, br, cr, dr;
    logic [31:0] o;
    logic        co, ovf;
  } mstate_t;
  typedef struct {
    logic [15:0] a, b, c;
    logic        sub;
    logic [31:0] exp_def;
    logic        exp_co;
    logic [31:0] exp_uns;
  } vec_t;
  typedef struct {
    longint res;
    bit     co, ovf;
  } lane_t;

  logic        clk = 1'b0;
  logic        rst_n, ce, ahold, bhold, chold, dhold, addsub, oload, ohold;
  logic [15:0] a, b, c, d;
  logic [31:0] o_w   [NI];
  logic        co_w  [NI];
  logic        ovf_w [NI];

  int      checks = 0;
  int      errors = 0;
  cfg_t    cfg [NI];
  mstate_t ms  [NI];
  vec_t    vt  [8];

  always #5 clk = ~clk;

  mac16_dsp u_def (.clk(clk), .rst_n(rst_n), .ce(ce), .a(a), .b(b), .c(c), .d(d),
    .ahold(ahold), .bhold(bhold), .chold(chold), .dhold(dhold), .addsub(addsub),
    .oload(oload), .ohold(ohold), .o(o_w[0]), .co(co_w[0]), .ovf(ovf_w[0]));
  mac16_dsp #(.A_SIGNED(1'b0)) u_uns (.clk(clk), .rst_n(rst_n), .ce(ce), .a(a), .b(b),
    .c(c), .d(d), .ahold(ahold), .bhold(bhold), .chold(chold), .dhold(dhold),
    .addsub(addsub), .oload(oload), .ohold(ohold), .o(o_w[1]), .co(co_w[1]), .ovf(ovf_w[1]));
  mac16_dsp #(.ACCUM(1'b1)) u_acc (.clk(clk), .rst_n(rst_n), .ce(ce), .a(a), .b(b),
    .c(c), .d(d), .ahold(ahold), .bhold(bhold), .chold(chold), .dhold(dhold),
    .addsub(addsub), .oload(oload), .ohold(ohold), .o(o_w[2]), .co(co_w[2]), .ovf(ovf_w[2]));
  mac16_dsp #(.MODE_8X8(1'b1)) u_8x8 (.clk(clk), .rst_n(rst_n), .ce(ce), .a(a), .b(b),
    .c(c), .d(d), .ahold(ahold), .bhold(bhold), .chold(chold), .dhold(dhold),
    .addsub(addsub), .oload(oload), .ohold(ohold), .o(o_w[3]), .co(co_w[3]), .ovf(ovf_w[3]));
  mac16_dsp #(.B_SIGNED(1'b0), .A_REG(1'b0), .B_REG(1'b0), .C_REG(1'b0), .D_REG(1'b1),
    .MODE_8X8(1'b1), .ACCUM(1'b1)) u_mix (.clk(clk), .rst_n(rst_n), .ce(ce), .a(a), .b(b),
    .c(c), .d(d), .ahold(ahold), .bhold(bhold), .chold(chold), .dhold(dhold),
    .addsub(addsub), .oload(oload), .ohold(ohold), .o(o_w[4]), .co(co_w[4]), .ovf(ovf_w[4]));

  // Value of the low w bits of v as a signed or unsigned integer.
  function automatic longint opval(input logic [15:0] v, input int w, input bit sgn);
    longint one, u;
    one = 1;
    u = longint'(v) & ((one << w) - 1);
    if (sgn && u >= (one << (w - 1))) u = u - (one << w);
    return u;
  endfunction

  // w-bit add/sub of unsigned x,y: wrapped result, carry/no-borrow, signed overflow.
  function automatic lane_t lane_op(input longint x, input longint y, input int w, input bit sub);
    lane_t  r;
    longint m, xs, ys, rs;
    m = longint'(1) << w;
    r.res = (sub ? (x - y) : (x + y)) & (m - 1);
    r.co  = sub ? (x >= y) : ((x + y) >= m);
    xs = (x >= m / 2) ? x - m : x;
    ys = (y >= m / 2) ? y - m : y;
    rs = sub ? (xs - ys) : (xs + ys);
    r.ovf = (rs >= m / 2) || (rs < -(m / 2));
    return r;
  endfunction

  function automatic mstate_t mstep(input mstate_t s, input cfg_t k,
                                    input logic [15:0] ia, ib, ic, id,
                                    input logic iah, ibh, ich, idh, isub, iol, ioh, ice);
    mstate_t     n;
    logic [15:0] ea, eb, ec, ed;
    longint      p, x, y, ph, pl, xh, yh, xl, yl;
    lane_t       lh, ll;
    n = s;
    if (!ice) return s;
    ea = k.a_reg ? s.ar : ia;
    eb = k.b_reg ? s.br : ib;
    ec = k.c_reg ? s.cr : ic;
    ed = k.d_reg ? s.dr : id;
    if (iol) begin
      n.o = {ic, id};
      n.co = 1'b0;
      n.ovf = 1'b0;
    end else if (!ioh) begin
      if (!k.mode8) begin
        p = (opval(ea, 16, k.a_signed) * opval(eb, 16, k.b_signed)) & 64'hFFFF_FFFF;
        x = k.accum ? longint'(s.o) : p;
        y = k.accum ? p : (opval(ec, 16, 1'b1) & 64'hFFFF_FFFF);
        lh = lane_op(x, y, 32, isub);
        n.o = 32'(lh.res);
      end else begin
        ph = (opval({8'b0, ea[15:8]}, 8, k.a_signed) * opval({8'b0, eb[15:8]}, 8, k.b_signed))
             & 64'hFFFF;
        pl = (opval({8'b0, ea[7:0]}, 8, k.a_signed) * opval({8'b0, eb[7:0]}, 8, k.b_signed))
             & 64'hFFFF;
        xh = k.accum ? longint'(s.o[31:16]) : ph;
        yh = k.accum ? ph : longint'(ec);
        xl = k.accum ? longint'(s.o[15:0]) : pl;
        yl = k.accum ? pl : longint'(ed);
        lh = lane_op(xh, yh, 16, isub);
        ll = lane_op(xl, yl, 16, isub);
        n.o = {16'(lh.res), 16'(ll.res)};
      end
      n.co  = lh.co;
      n.ovf = OVF_EN && lh.ovf;
    end
    if (k.a_reg && !iah) n.ar = ia;
    if (k.b_reg && !ibh) n.br = ib;
    if (k.c_reg && !ich) n.cr = ic;
    if (k.d_reg && !idh) n.dr = id;
    return n;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) ms[i] = '{16'h0, 16'h0, 16'h0, 16'h0, 32'h0, 1'b0, 1'b0};
  endtask

  // One clock edge: advance the models with the inputs seen at the edge, then compare.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else
      for (int i = 0; i < NI; i++)
        ms[i] = mstep(ms[i], cfg[i], a, b, c, d, ahold, bhold, chold, dhold,
                      addsub, oload, ohold, ce);
    #2;
    for (int i = 0; i < NI; i++) begin
      chk32($sformatf("model_o[%0d]", i), o_w[i], ms[i].o);
      chk1($sformatf("model_co[%0d]", i), co_w[i], ms[i].co);
      chk1($sformatf("model_ovf[%0d]", i), ovf_w[i], ms[i].ovf);
    end
  endtask

  // Async reset pulse between edges; outputs must clear without a clock.
  task automatic reset_pulse(input string name);
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < NI; i++) begin
      chk32($sformatf("%s_o[%0d]", name, i), o_w[i], 32'h0);
      chk1($sformatf("%s_co[%0d]", name, i), co_w[i], 1'b0);
      chk1($sformatf("%s_ovf[%0d]", name, i), ovf_w[i], 1'b0);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    cfg[0] = '{1, 1, 1, 1, 1, 0, 0, 0};
    cfg[1] = '{0, 1, 1, 1, 1, 0, 0, 0};
    cfg[2] = '{1, 1, 1, 1, 1, 0, 0, 1};
    cfg[3] = '{1, 1, 1, 1, 1, 0, 1, 0};
    cfg[4] = '{1, 0, 0, 0, 0, 1, 1, 1};
    vt[0] = '{16'd5,    16'd3,    16'd10,   1'b0, 32'h0000_0019, 1'b0, 32'h0000_0019};
    vt[1] = '{16'hFFFE, 16'd3,    16'd0,    1'b0, 32'hFFFF_FFFA, 1'b0, 32'h0002_FFFA};
    vt[2] = '{16'd5,    16'd3,    16'd10,   1'b1, 32'h0000_0005, 1'b1, 32'h0000_0005};
    vt[3] = '{16'd5,    16'd3,    16'd20,   1'b1, 32'hFFFF_FFFB, 1'b0, 32'hFFFF_FFFB};
    vt[4] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0, 32'h3FFF_8000, 1'b0, 32'h3FFF_8000};
    vt[5] = '{16'h8000, 16'h8000, 16'h0000, 1'b0, 32'h4000_0000, 1'b0, 32'hC000_0000};
    vt[6] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 32'h0000_0000, 1'b1, 32'hFFFF_0000};
    vt[7] = '{16'h0000, 16'h0000, 16'h8000, 1'b1, 32'h0000_8000, 1'b0, 32'h0000_8000};

    model_reset();
    rst_n = 1'b0; ce = 1'b1;
    ahold = 1'b0; bhold = 1'b0; chold = 1'b0; dhold = 1'b0;
    addsub = 1'b0; oload = 1'b0; ohold = 1'b0;
    a = 16'h0; b = 16'h0; c = 16'h0; d = 16'h0;
    #12;
    for (int i = 0; i < NI; i++) begin
      chk32($sformatf("reset_o[%0d]", i), o_w[i], 32'h0);
      chk1($sformatf("reset_co[%0d]", i), co_w[i], 1'b0);
    end
    rst_n = 1'b1;

    // Table vectors, each held for the two-edge latency.
    for (int v = 0; v < 8; v++) begin
      a = vt[v].a; b = vt[v].b; c = vt[v].c; d = 16'h0; addsub = vt[v].sub;
      tick();
      tick();
      chk32($sformatf("vec%0d_o", v), o_w[0], vt[v].exp_def);
      chk1($sformatf("vec%0d_co", v), co_w[0], vt[v].exp_co);
      chk32($sformatf("vec%0d_uns_o", v), o_w[1], vt[v].exp_uns);
    end

    // Result persists, then ce=0 freezes everything even with oload asserted.
    a = 16'd5; b = 16'd3; c = 16'd10; addsub = 1'b0;
    tick(); tick(); tick();
    chk32("hold_25", o_w[0], 32'h19);
    ce = 1'b0; a = 16'd9; b = 16'd9; c = 16'd1; oload = 1'b1;
    tick(); tick(); tick();
    chk32("ce0_freeze", o_w[0], 32'h19);
    ce = 1'b1; c = 16'h1234; d = 16'h5678;
    tick();
    chk32("oload_o", o_w[0], 32'h1234_5678);
    chk1("oload_co", co_w[0], 1'b0);
    oload = 1'b0; ohold = 1'b1; a = 16'd7; c = 16'd3;
    tick(); tick();
    chk32("ohold_o", o_w[0], 32'h1234_5678);
    ohold = 1'b0; a = 16'd5; b = 16'd3; c = 16'd10; d = 16'h0;
    tick();

    // Reset mid-stream, then first result two edges later; accumulator steps by 15.
    reset_pulse("midrst");
    tick();
    chk32("post_rst_e1", o_w[0], 32'h0);
    tick();
    chk32("post_rst_e2", o_w[0], 32'h19);
    chk32("acc_15", o_w[2], 32'd15);
    tick();
    chk32("acc_30", o_w[2], 32'd30);
    tick();
    chk32("acc_45", o_w[2], 32'd45);
    tick();
    chk32("acc_60", o_w[2], 32'd60);

    // 8x8 lanes: lo lane wraps and its carry must not reach the hi lane.
    a = 16'h02FF; b = 16'h0301; c = 16'h0001; d = 16'hFFFF;
    tick(); tick();
    chk32("lane_isolation", o_w[3], 32'h0007_FFFE);
    chk1("lane_co", co_w[3], 1'b0);

    // Accumulating 0x7FFF^2 until the sign flips.
    a = 16'h7FFF; b = 16'h7FFF; c = 16'h0; d = 16'h0;
    reset_pulse("ovfrst");
    tick(); tick();
    chk32("acc_sq1", o_w[2], 32'h3FFF_0001);
    tick();
    chk32("acc_sq2", o_w[2], 32'h7FFE_0002);
    chk1("acc_sq2_ovf", ovf_w[2], 1'b0);
    tick();
    chk32("acc_sq3", o_w[2], 32'hBFFD_0003);
    chk1("acc_sq3_ovf", ovf_w[2], OVF_EN);

    // Random stimulus against the model.
    for (int n = 0; n < 600; n++) begin
      a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
      ce     = ($urandom_range(0, 7) != 0);
      ahold  = ($urandom_range(0, 3) == 0);
      bhold  = ($urandom_range(0, 3) == 0);
      chold  = ($urandom_range(0, 3) == 0);
      dhold  = ($urandom_range(0, 3) == 0);
      addsub = 1'($urandom);
      oload  = ($urandom_range(0, 15) == 0);
      ohold  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 99) == 0) reset_pulse("rnd_rst");
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
